shift_unit_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit ALU shift unit.
- Shifts or rotates an operand by a programmable amount, one bit position per clock.
- Uses a start/busy/done handshake and reports the last bit shifted out.
- Sits in the ALU datapath beside the arithmetic/logic units and is started by the ALU controller.

---
 rtl/shift_unit_seq.sv | 121 ++++++++++++
 tb/tb_shift_unit_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
// State table:  IDLE | waiting for Shift_Enable   RUN | stepping W until CNT reaches zero
module shift_unit_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Shift_Enable,
  input  logic [2:0]             OP,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [SHAMT_WIDTH-1:0] SHAMT,
  output logic [DATA_WIDTH-1:0]  Shift_OUT,
  output logic                   Shift_Flag,
  output logic                   Carry_Out,
  output logic                   Busy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [DATA_WIDTH-1:0]  r_work;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic [2:0]             r_op;
  logic                   r_carry;
  logic [DATA_WIDTH-1:0]  w_step_work;
  logic                   w_step_carry;
  logic                   w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Single-position step of the latched operation; PASS codes leave W and carry alone.
  always_comb begin
    w_step_work  = r_work;
    w_step_carry = r_carry;
    case (r_op)
      OP_SLL: begin
        w_step_work  = {r_work[DATA_WIDTH-2:0], 1'b0};
        w_step_carry = r_work[DATA_WIDTH-1];
      end
      OP_SRL: begin
        w_step_work  = {1'b0, r_work[DATA_WIDTH-1:1]};
        w_step_carry = r_work[0];
      end
      OP_SRA: begin
        w_step_work  = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
        w_step_carry = r_work[0];
      end
      OP_ROL: begin
        w_step_work  = {r_work[DATA_WIDTH-2:0], r_work[DATA_WIDTH-1]};
        w_step_carry = r_work[DATA_WIDTH-1];
      end
      OP_ROR: begin
        w_step_work  = {r_work[0], r_work[DATA_WIDTH-1:1]};
        w_step_carry = r_work[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (Shift_Enable) w_next_state = S_RUN;
      S_RUN:   if (w_cnt_zero)   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_carry    <= 1'b0;
      Shift_OUT  <= '0;
      Shift_Flag <= 1'b0;
      Carry_Out  <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Shift_Flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Shift_Enable) begin
            r_work  <= A;
            r_cnt   <= SHAMT;
            r_op    <= OP;
            r_carry <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (!w_cnt_zero) begin
            r_work  <= w_step_work;
            r_carry <= w_step_carry;
            r_cnt   <= r_cnt - SHAMT_WIDTH'(1);
          end else begin
            Shift_OUT  <= r_work;
            Carry_Out  <= r_carry;
            Shift_Flag <= 1'b1;
            Busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: hand-computed results, busy-cycle counts and handshake timing.
module tb_shift_unit_seq;

  logic       CLK;
  logic       RST;
  logic       Shift_Enable;
  logic [2:0] OP;
  logic [7:0] A;
  logic [3:0] SHAMT;
  logic [7:0] Shift_OUT;
  logic       Shift_Flag;
  logic       Carry_Out;
  logic       Busy;

  int checks = 0;
  int passed = 0;

  shift_unit_seq #(.DATA_WIDTH(8), .SHAMT_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .Shift_Enable(Shift_Enable), .OP(OP), .A(A), .SHAMT(SHAMT),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag), .Carry_Out(Carry_Out), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Starts at a negedge, returns at a negedge one cycle after the done pulse.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [3:0] sh, input logic [7:0] exp_out, input logic exp_c);
    int n;
    OP = op; A = a; SHAMT = sh; Shift_Enable = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Shift_Enable = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      A = 8'($urandom); SHAMT = 4'($urandom); OP = 3'($urandom);
      @(negedge CLK);
    end
    chk({tag, " busy_cycles"}, n, 32'(sh) + 1);
    chk({tag, " flag"}, Shift_Flag, 1'b1);
    chk({tag, " out"}, Shift_OUT, exp_out);
    chk({tag, " carry"}, Carry_Out, exp_c);
    @(negedge CLK);
    chk({tag, " flag_one_cycle"}, Shift_Flag, 1'b0);
    chk({tag, " out_held"}, Shift_OUT, exp_out);
  endtask

  initial begin
    int saw_flag;
    RST = 1'b0; Shift_Enable = 1'b0; OP = '0; A = '0; SHAMT = '0;
    repeat (2) @(negedge CLK);
    chk("reset out", Shift_OUT, 8'h00);
    chk("reset flag", Shift_Flag, 1'b0);
    chk("reset carry", Carry_Out, 1'b0);
    chk("reset busy", Busy, 1'b0);
    RST = 1'b1;
    @(negedge CLK);

    do_op("sll_96_3", 3'b000, 8'h96, 4'd3, 8'hB0, 1'b0);

    // Abort a run with reset: outputs must clear immediately with no done pulse.
    OP = 3'b000; A = 8'hFF; SHAMT = 4'd5; Shift_Enable = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Shift_Enable = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("midrun busy_before_reset", Busy, 1'b1);
    #1 RST = 1'b0;
    #1;
    chk("midrun reset out", Shift_OUT, 8'h00);
    chk("midrun reset busy", Busy, 1'b0);
    chk("midrun reset flag", Shift_Flag, 1'b0);
    chk("midrun reset carry", Carry_Out, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    saw_flag = 0;
    repeat (8) begin
      @(negedge CLK);
      if (Shift_Flag === 1'b1 || Busy === 1'b1) saw_flag++;
    end
    chk("midrun no_flag_after_abort", saw_flag, 0);

    do_op("srl_80_1", 3'b001, 8'h80, 4'd1, 8'h40, 1'b0);
    do_op("sra_90_2", 3'b010, 8'h90, 4'd2, 8'hE4, 1'b0);
    do_op("sra_81_12", 3'b010, 8'h81, 4'd12, 8'hFF, 1'b1);
    do_op("rol_81_1", 3'b011, 8'h81, 4'd1, 8'h03, 1'b1);
    do_op("ror_01_9", 3'b100, 8'h01, 4'd9, 8'h80, 1'b1);
    do_op("sll_81_15", 3'b000, 8'h81, 4'd15, 8'h00, 1'b0);
    do_op("srl_5a_0", 3'b001, 8'h5A, 4'd0, 8'h5A, 1'b0);
    do_op("pass_3c_2", 3'b110, 8'h3C, 4'd2, 8'h3C, 1'b0);

    // Enable held high: a new op every 3 cycles; inputs scrambled while busy.
    OP = 3'b001; A = 8'h80; SHAMT = 4'd1; Shift_Enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge CLK);
      chk($sformatf("b2b flag@%0d", i), Shift_Flag, (i % 3 == 0));
      if (i % 3 == 0) begin
        chk($sformatf("b2b out@%0d", i), Shift_OUT, 8'h40);
        chk($sformatf("b2b carry@%0d", i), Carry_Out, 1'b0);
      end
      if (Busy === 1'b1) begin
        A = 8'($urandom); SHAMT = 4'($urandom); OP = 3'($urandom);
      end else begin
        OP = 3'b001; A = 8'h80; SHAMT = 4'd1;
      end
      if (i == 15) Shift_Enable = 1'b0;
    end
    @(negedge CLK);
    chk("b2b idle_after_release", Busy, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
